timing_machine_cycle_sequencer: RTL and testbench



---
 rtl/norz_timing_pkg.sv | 49 ++++
 rtl/timing_xpt_counter.sv | 49 ++++
 rtl/timing_machine_cycle_sequencer.sv | 126 ++++++++++++
 tb/tb_timing_machine_cycle_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/norz_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : norz_timing_pkg
// Purpose  : Shared constants and helpers for the machine-cycle sequencer.
//            This package holds the T-state codes, the cycle-type codes and
//            the default width of the instruction phase counter.
// Revision : 1.0  initial release
// ============================================================================
package norz_timing_pkg;

  // Default width of the instruction phase counter XPT
  localparam int XPT_W_DEFAULT = 5;

  // T-state codes, as seen on the TSTATE output
  localparam logic [2:0] T1 = 3'd0;
  localparam logic [2:0] T2 = 3'd1;
  localparam logic [2:0] TW = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  // Machine-cycle types
  localparam logic CYC_M1 = 1'b0;  // opcode fetch, four T-states
  localparam logic CYC_MR = 1'b1;  // memory read, three T-states

  // Active-low bus strobes, grouped so they can be computed together
  typedef struct packed {
    logic n_m1;
    logic n_mreq;
    logic n_rd;
  } strobes_t;

  // True when t is the final T-state of a machine cycle of type cyc
  function automatic logic is_last_tstate(input logic [2:0] t, input logic cyc);
    return (cyc == CYC_M1) ? (t == T4) : (t == T3);
  endfunction

  // Strobe levels that belong to T-state t of a cycle of type cyc
  function automatic strobes_t strobes_for(input logic [2:0] t, input logic cyc);
    strobes_t s;
    logic     addr_phase;
    addr_phase = (t == T2) || (t == TW);
    s.n_m1     = !((cyc == CYC_M1) && ((t == T1) || addr_phase));
    s.n_mreq   = !(addr_phase || ((t == T3) && (cyc == CYC_MR)));
    s.n_rd     = s.n_mreq;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timing_xpt_counter.sv
`default_nettype none
// ============================================================================
// Module   : timing_xpt_counter
// Purpose  : Instruction phase counter. Saturates at its maximum value, has a
//            synchronous clear and a hold (enable) input, and keeps a
//            registered complement so both polarities change on one edge.
// Revision : 1.0  initial release
// ============================================================================
module timing_xpt_counter
  import norz_timing_pkg::*;
#(
  parameter int XPT_W = XPT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             inc,
  output logic [XPT_W-1:0] xpt,
  output logic [XPT_W-1:0] not_xpt
);

  localparam logic [XPT_W-1:0] XPT_MAX = '1;
  localparam logic [XPT_W-1:0] XPT_ONE = {{(XPT_W-1){1'b0}}, 1'b1};

  logic [XPT_W-1:0] xpt_plus;
  logic             at_max;

  assign xpt_plus = xpt + XPT_ONE;
  assign at_max   = (xpt == XPT_MAX);

  // Count, clear or hold; the complement is loaded alongside the true value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xpt     <= '0;
      not_xpt <= '1;
    end else if (en) begin
      if (clr) begin
        xpt     <= '0;
        not_xpt <= '1;
      end else if (inc && !at_max) begin
        xpt     <= xpt_plus;
        not_xpt <= ~xpt_plus;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/timing_machine_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : timing_machine_cycle_sequencer
// Purpose  : CPU bus timing. Runs the T-state machine within each machine
//            cycle (M1 opcode fetch / MR memory read), honours the memory
//            wait handshake, owns the instruction phase counter XPT and
//            drives registered bus strobes and latch pulses.
// Revision : 1.0  initial release
// ============================================================================
module timing_machine_cycle_sequencer
  import norz_timing_pkg::*;
#(
  parameter int XPT_W = XPT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             notRESET,
  input  logic             enable,
  input  logic             PR_Reset_XPT,
  input  logic             P2_Set_CM1,
  input  logic             P2_Set_CMR,
  input  logic             notWAIT,
  output logic [XPT_W-1:0] XPT,
  output logic [XPT_W-1:0] notXPT,
  output logic             CM1,
  output logic             CMR,
  output logic [2:0]       TSTATE,
  output logic             notM1,
  output logic             notMREQ,
  output logic             notRD,
  output logic             Latch_Opcode,
  output logic             Latch_Data
);

  logic       cur_cyc;
  logic       cycle_end;
  logic [2:0] tstate_nxt;
  logic       cyc_nxt;
  logic       xpt_inc;
  logic       xpt_clr;
  logic       lop_nxt;
  logic       ldat_nxt;
  strobes_t   strb_nxt;

  // CM1 and CMR are kept as separate registers; CM1 is the authoritative one
  assign cur_cyc   = CM1 ? CYC_M1 : CYC_MR;
  assign cycle_end = is_last_tstate(TSTATE, cur_cyc);

  // Next T-state, next cycle type, counter control and latch pulse decode
  always_comb begin
    tstate_nxt = T1;
    cyc_nxt    = cur_cyc;
    xpt_clr    = 1'b0;
    lop_nxt    = 1'b0;
    ldat_nxt   = 1'b0;
    // Every T-state exit advances XPT except leaving (or staying in) TW
    xpt_inc    = (TSTATE != TW);

    case (TSTATE)
      T1: tstate_nxt = T2;
      T2, TW: begin
        // notWAIT is only looked at on the edge that ends T2 or TW
        tstate_nxt = notWAIT ? T3 : TW;
        lop_nxt    = notWAIT && (cur_cyc == CYC_M1);
      end
      T3: begin
        tstate_nxt = (cur_cyc == CYC_M1) ? T4 : T1;
        ldat_nxt   = (cur_cyc == CYC_MR);
      end
      T4:      tstate_nxt = T1;
      default: tstate_nxt = T1;  // unused codes recover to the start of a cycle
    endcase

    // Decoder requests only matter on the last T-state of the cycle
    if (cycle_end) begin
      if (PR_Reset_XPT) begin
        xpt_clr = 1'b1;
        cyc_nxt = CYC_M1;
      end else if (P2_Set_CM1) begin
        cyc_nxt = CYC_M1;
      end else if (P2_Set_CMR) begin
        cyc_nxt = CYC_MR;
      end else begin
        cyc_nxt = CYC_M1;
      end
    end

    strb_nxt = strobes_for(tstate_nxt, cyc_nxt);
  end

  // T-state, cycle type, strobes and latch pulses; everything holds when disabled
  always_ff @(posedge CLK or negedge notRESET) begin
    if (!notRESET) begin
      TSTATE       <= T1;
      CM1          <= 1'b1;
      CMR          <= 1'b0;
      notM1        <= 1'b1;
      notMREQ      <= 1'b1;
      notRD        <= 1'b1;
      Latch_Opcode <= 1'b0;
      Latch_Data   <= 1'b0;
    end else if (enable) begin
      TSTATE       <= tstate_nxt;
      CM1          <= (cyc_nxt == CYC_M1);
      CMR          <= (cyc_nxt == CYC_MR);
      notM1        <= strb_nxt.n_m1;
      notMREQ      <= strb_nxt.n_mreq;
      notRD        <= strb_nxt.n_rd;
      Latch_Opcode <= lop_nxt;
      Latch_Data   <= ldat_nxt;
    end
  end

  timing_xpt_counter #(
    .XPT_W (XPT_W)
  ) u_xpt (
    .clk     (CLK),
    .rst_n   (notRESET),
    .en      (enable),
    .clr     (xpt_clr),
    .inc     (xpt_inc),
    .xpt     (XPT),
    .not_xpt (notXPT)
  );

endmodule
`default_nettype wire

// File: tb/tb_timing_machine_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_timing_machine_cycle_sequencer
// Purpose  : Directed bench with a scoreboard queue for the machine-cycle
//            sequencer. Each stimulus cycle pushes the hand-derived outputs
//            for that cycle; a monitor pops and compares on the falling edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_timing_machine_cycle_sequencer;
  import norz_timing_pkg::*;

  logic       CLK = 1'b0;
  logic       notRESET;
  logic       enable;
  logic       PR_Reset_XPT;
  logic       P2_Set_CM1;
  logic       P2_Set_CMR;
  logic       notWAIT;
  logic [4:0] XPT;
  logic [4:0] notXPT;
  logic       CM1;
  logic       CMR;
  logic [2:0] TSTATE;
  logic       notM1;
  logic       notMREQ;
  logic       notRD;
  logic       Latch_Opcode;
  logic       Latch_Data;

  typedef struct packed {
    logic [4:0] xpt;
    logic [2:0] ts;
    logic       cm1;
    logic       cmr;
    logic       nm1;
    logic       nmreq;
    logic       nrd;
    logic       lop;
    logic       ldat;
  } exp_t;

  exp_t q[$];
  exp_t e_m;
  exp_t a_m;
  int   checks = 0;
  int   passes = 0;

  timing_machine_cycle_sequencer #(.XPT_W(5)) dut (
    .CLK          (CLK),
    .notRESET     (notRESET),
    .enable       (enable),
    .PR_Reset_XPT (PR_Reset_XPT),
    .P2_Set_CM1   (P2_Set_CM1),
    .P2_Set_CMR   (P2_Set_CMR),
    .notWAIT      (notWAIT),
    .XPT          (XPT),
    .notXPT       (notXPT),
    .CM1          (CM1),
    .CMR          (CMR),
    .TSTATE       (TSTATE),
    .notM1        (notM1),
    .notMREQ      (notMREQ),
    .notRD        (notRD),
    .Latch_Opcode (Latch_Opcode),
    .Latch_Data   (Latch_Data)
  );

  always #5 CLK = ~CLK;

  function automatic exp_t mk(input logic [4:0] x, input logic [2:0] t,
                              input logic cm1, input logic cmr, input logic nm1,
                              input logic nmreq, input logic nrd,
                              input logic lop, input logic ldat);
    exp_t e;
    e = {x, t, cm1, cmr, nm1, nmreq, nrd, lop, ldat};
    return e;
  endfunction

  // Hand-derived outputs for each T-state of a wait-free M1 cycle
  function automatic exp_t m1_exp(input int ph, input logic [4:0] x);
    case (ph)
      0:       return mk(x, T1, 1, 0, 0, 1, 1, 0, 0);
      1:       return mk(x, T2, 1, 0, 0, 0, 0, 0, 0);
      2:       return mk(x, T3, 1, 0, 1, 1, 1, 1, 0);
      default: return mk(x, T4, 1, 0, 1, 1, 1, 0, 0);
    endcase
  endfunction

  // One cycle: expected outputs for this cycle, inputs for the coming edge
  task automatic cyc(input logic pr, input logic s1, input logic sr,
                     input logic nw, input logic en, input exp_t e);
    @(posedge CLK);
    #1;
    PR_Reset_XPT = pr;
    P2_Set_CM1   = s1;
    P2_Set_CMR   = sr;
    notWAIT      = nw;
    enable       = en;
    q.push_back(e);
  endtask

  // Monitor: compare every presented expectation against the DUT outputs
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      e_m = q.pop_front();
      a_m = {XPT, TSTATE, CM1, CMR, notM1, notMREQ, notRD, Latch_Opcode, Latch_Data};
      checks++;
      if (a_m == e_m) passes++;
      else $display("FAIL outputs @%0t: actual xpt=%0d ts=%0d cm1=%b cmr=%b nm1=%b nmreq=%b nrd=%b lop=%b ldat=%b required xpt=%0d ts=%0d cm1=%b cmr=%b nm1=%b nmreq=%b nrd=%b lop=%b ldat=%b",
                    $time, a_m.xpt, a_m.ts, a_m.cm1, a_m.cmr, a_m.nm1, a_m.nmreq, a_m.nrd, a_m.lop, a_m.ldat,
                    e_m.xpt, e_m.ts, e_m.cm1, e_m.cmr, e_m.nm1, e_m.nmreq, e_m.nrd, e_m.lop, e_m.ldat);
      checks++;
      if (notXPT == ~e_m.xpt) passes++;
      else $display("FAIL notXPT @%0t: actual %0d required %0d", $time, notXPT, ~e_m.xpt);
    end
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  exp_t rst_e;

  initial begin
    rst_e        = mk(0, T1, 1, 0, 1, 1, 1, 0, 0);
    notRESET     = 1'b0;
    enable       = 1'b1;
    PR_Reset_XPT = 1'b0;
    P2_Set_CM1   = 1'b0;
    P2_Set_CMR   = 1'b0;
    notWAIT      = 1'b1;

    // Reset state, released right after an edge
    repeat (2) @(posedge CLK);
    #1;
    q.push_back(rst_e);
    notRESET = 1'b1;

    // Free-running M1, then PR_Reset_XPT at T4 with XPT=3
    cyc(0, 0, 0, 1, 1, mk(1, T2, 1, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 1, 1, mk(2, T3, 1, 0, 1, 1, 1, 1, 0));
    cyc(1, 0, 0, 1, 1, mk(3, T4, 1, 0, 1, 1, 1, 0, 0));
    // PR held through T1/T2 must be ignored; CMR request at M1 T3 ignored
    cyc(1, 0, 0, 1, 1, mk(0, T1, 1, 0, 0, 1, 1, 0, 0));
    cyc(1, 0, 0, 1, 1, mk(1, T2, 1, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 1, 1, 1, mk(2, T3, 1, 0, 1, 1, 1, 1, 0));
    // CMR request at T4: next cycle is MR
    cyc(0, 0, 1, 1, 1, mk(3, T4, 1, 0, 1, 1, 1, 0, 0));
    cyc(0, 0, 0, 1, 1, mk(4, T1, 0, 1, 1, 1, 1, 0, 0));
    cyc(0, 0, 0, 1, 1, mk(5, T2, 0, 1, 1, 0, 0, 0, 0));
    // MR T3 frozen for two cycles; both set requests -> next is M1
    cyc(0, 1, 1, 1, 0, mk(6, T3, 0, 1, 1, 0, 0, 0, 0));
    cyc(0, 1, 1, 1, 0, mk(6, T3, 0, 1, 1, 0, 0, 0, 0));
    cyc(0, 1, 1, 1, 1, mk(6, T3, 0, 1, 1, 0, 0, 0, 0));
    cyc(0, 0, 0, 1, 1, mk(7, T1, 1, 0, 0, 1, 1, 0, 1));
    // Three wait states in M1
    cyc(0, 0, 0, 0, 1, mk(8, T2, 1, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 0, 1, mk(9, TW, 1, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 0, 1, mk(9, TW, 1, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 1, 1, mk(9, TW, 1, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 1, 1, mk(9, T3, 1, 0, 1, 1, 1, 1, 0));
    cyc(0, 0, 0, 1, 1, mk(10, T4, 1, 0, 1, 1, 1, 0, 0));

    // Run XPT up to saturation, then clear it at a T4
    for (int k = 0; k < 24; k++) begin
      int xi;
      xi = 11 + k;
      if (xi > 31) xi = 31;
      cyc((k == 23), 0, 0, 1, 1, m1_exp(k % 4, xi[4:0]));
    end
    cyc(0, 0, 0, 1, 1, mk(0, T1, 1, 0, 0, 1, 1, 0, 0));

    // Enter TW, then pull reset mid-cycle (no clock edge before the check)
    cyc(0, 0, 0, 0, 1, mk(1, T2, 1, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 0, 1, mk(2, TW, 1, 0, 0, 0, 0, 0, 0));
    @(posedge CLK);
    #1;
    notRESET = 1'b0;
    notWAIT  = 1'b1;
    q.push_back(rst_e);
    @(posedge CLK);
    #1;
    q.push_back(rst_e);
    @(posedge CLK);
    #1;
    q.push_back(rst_e);
    notRESET = 1'b1;
    cyc(0, 0, 0, 1, 1, mk(1, T2, 1, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 1, 1, mk(2, T3, 1, 0, 1, 1, 1, 1, 0));
    cyc(0, 0, 0, 1, 1, mk(3, T4, 1, 0, 1, 1, 1, 0, 0));
    cyc(0, 0, 0, 1, 1, mk(4, T1, 1, 0, 0, 1, 1, 0, 0));

    // Drain the scoreboard within a bounded number of cycles
    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge CLK);
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: actual %0d pending entries required 0", q.size());
    end
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
